aes_dec_round_ctrl: RTL and testbench



---
 rtl/aes_dec_round_ctrl.sv | 88 ++++++++
 tb/tb_aes_dec_round_ctrl.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: initial AddRoundKey, then NR rounds through an external datapath.
// Latency NR+2 cycles from accept to out_valid; one block in flight, out_data held while out_ready is low.
module aes_dec_round_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic [3:0]   rk_addr,
  input  logic [127:0] rk_data,
  output logic [127:0] dp_state,
  output logic         dp_last,
  input  logic [127:0] dp_result,
  output logic         busy
);

  localparam logic [3:0] LAST_RK = 4'(NR);

  typedef enum logic [1:0] {IDLE, LOAD, ROUND, DONE} fsm_t;

  fsm_t         fsm;
  logic [127:0] state;
  logic [127:0] ct_hold;
  logic [3:0]   cnt;

  assign out_data = state;
  assign dp_state = state;

  // rk_addr runs one cycle ahead of the round that consumes it, since the key RAM is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= IDLE;
      state     <= '0;
      ct_hold   <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      dp_last   <= 1'b0;
      rk_addr   <= LAST_RK;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            ct_hold  <= in_data;
            fsm      <= LOAD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            rk_addr  <= LAST_RK - 4'd1;
          end
        end
        LOAD: begin
          state   <= ct_hold ^ rk_data;
          cnt     <= LAST_RK - 4'd1;
          fsm     <= ROUND;
          rk_addr <= LAST_RK - 4'd2;
        end
        ROUND: begin
          state <= dp_result;
          if (cnt == 4'd0) begin
            fsm       <= DONE;
            dp_last   <= 1'b0;
            out_valid <= 1'b1;
            rk_addr   <= LAST_RK;
          end else begin
            cnt     <= cnt - 4'd1;
            dp_last <= (cnt == 4'd1);
            rk_addr <= (cnt == 4'd1) ? LAST_RK : cnt - 4'd2;
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// Bench for aes_dec_round_ctrl: NR=10 and NR=14 instances with a key RAM and inverse-round datapath model;
// expected plaintext comes from a forward-cipher reference, compared by a negedge monitor.
module tb_aes_dec_round_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [1:0]   in_valid, in_ready, out_valid, out_ready, dp_last, busy;
  logic [127:0] in_data [2];
  logic [127:0] out_data [2];
  logic [127:0] rk_data [2];
  logic [127:0] dp_state [2];
  logic [127:0] dp_result [2];
  logic [3:0]   rk_addr [2];
  logic [127:0] rk_mem [2][16];

  typedef struct {
    int           inst;
    logic [127:0] pt;
    int           acc;
  } exp_t;
  exp_t sbq[$];
  int   npush = 0;
  int   nout = 0;

  // ---------------- GF(2^8) / AES primitives ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] base = a;
    logic [7:0] e = 8'd254;
    for (int k = 0; k < 8; k++) begin
      if (e[k]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return ginv(rotl(y, 1) ^ rotl(y, 3) ^ rotl(y, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] x, input int k);
    return x[127-8*k -: 8];
  endfunction

  function automatic logic [127:0] fwd_sub_shift(input logic [127:0] x);
    logic [127:0] y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(r+4*c) -: 8] = sbox(gb(x, r + 4*((c + r) % 4)));
    return y;
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] x);
    logic [127:0] y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        y[127-8*(r+4*((c + r) % 4)) -: 8] = inv_sbox(gb(x, r + 4*c));
    return y;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] x, input logic [31:0] co);
    logic [127:0] y = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(co[31-8*((j - r + 4) % 4) -: 8], gb(x, j + 4*c));
        y[127-8*(r+4*c) -: 8] = acc;
      end
    return y;
  endfunction

  function automatic logic [127:0] inv_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] y;
    y = inv_sub_shift(st) ^ rk;
    if (!last) y = mix_cols(y, 32'h0e0b0d09);
    return y;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic int nr_of(input int i);
    return (i == 0) ? 10 : 14;
  endfunction

  // Forward cipher: the reference that produces ciphertext for a known plaintext.
  function automatic logic [127:0] enc(input int i, input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ rk_mem[i][0];
    for (int rd = 1; rd <= nr_of(i); rd++) begin
      s = fwd_sub_shift(s);
      if (rd < nr_of(i)) s = mix_cols(s, 32'h02030101);
      s = s ^ rk_mem[i][rd];
    end
    return s;
  endfunction

  function automatic logic [127:0] r128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic expand(input int i, input logic [255:0] key, input int nk);
    logic [31:0] w[60];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    int          nr;
    nr = nk + 6;
    for (int k = 0; k < nk; k++) w[k] = key[255-32*k -: 32];
    for (int k = nk; k < 4*(nr+1); k++) begin
      t = w[k-1];
      if (k % nk == 0) begin
        t = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && k % nk == 4) begin
        t = subw(t);
      end
      w[k] = w[k-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rk_mem[i][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- DUTs, key RAMs and datapaths ----------------
  aes_dec_round_ctrl #(.NR(10)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .rk_addr(rk_addr[0]), .rk_data(rk_data[0]),
    .dp_state(dp_state[0]), .dp_last(dp_last[0]), .dp_result(dp_result[0]),
    .busy(busy[0])
  );

  aes_dec_round_ctrl #(.NR(14)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .rk_addr(rk_addr[1]), .rk_data(rk_data[1]),
    .dp_state(dp_state[1]), .dp_last(dp_last[1]), .dp_result(dp_result[1]),
    .busy(busy[1])
  );

  always @(posedge clk) begin
    rk_data[0] <= rk_mem[0][rk_addr[0]];
    rk_data[1] <= rk_mem[1][rk_addr[1]];
  end

  assign dp_result[0] = inv_round(dp_state[0], rk_data[0], dp_last[0]);
  assign dp_result[1] = inv_round(dp_state[1], rk_data[1], dp_last[1]);

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int           tr [2][20];
  int           tr_n [2];
  bit           seen [2];
  int           dl_cnt [2];
  logic [127:0] hold [2];

  initial begin
    exp_t e;
    int   bad;
    int   want;
    for (int i = 0; i < 2; i++) begin
      tr_n[i] = 0; seen[i] = 0; dl_cnt[i] = 0; hold[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (rst) begin
          tr_n[i] = 0; seen[i] = 0; dl_cnt[i] = 0;
        end else begin
          if (in_valid[i] && in_ready[i]) begin
            tr_n[i] = 0;
            dl_cnt[i] = 0;
          end
          if ((in_valid[i] && in_ready[i]) || (busy[i] && !out_valid[i])) begin
            if (tr_n[i] < 20) tr[i][tr_n[i]] = int'(rk_addr[i]);
            tr_n[i]++;
          end
          if (dp_last[i]) begin
            dl_cnt[i]++;
            check("dp_last_rk_addr", rk_addr[i], nr_of(i));
          end
          if (!busy[i] || out_valid[i]) check("dp_last_outside_round", dp_last[i], 0);
          if (out_valid[i]) begin
            check("in_ready_in_done", in_ready[i], 0);
            if (!seen[i]) begin
              seen[i] = 1;
              if (sbq.size() == 0 || sbq[0].inst != i) begin
                hold[i] = out_data[i];
                check("unexpected_output", out_valid[i], 0);
              end else begin
                e = sbq.pop_front();
                hold[i] = e.pt;
                check("plaintext", out_data[i], e.pt);
                check("latency", cyc - e.acc, nr_of(i) + 2);
                bad = (tr_n[i] == nr_of(i) + 2) ? 0 : 1;
                for (int k = 0; k < tr_n[i] && k < 20; k++) begin
                  want = (k == 0 || k > nr_of(i)) ? nr_of(i) : nr_of(i) - k;
                  if (tr[i][k] != want) bad++;
                end
                check("rk_addr_trace", bad, 0);
                check("dp_last_count", dl_cnt[i], 1);
              end
            end else begin
              check("hold_data", out_data[i], hold[i]);
            end
            if (out_ready[i]) begin
              seen[i] = 0;
              nout++;
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [127:0] ct, input logic [127:0] pt, output int acc);
    int n = 0;
    in_data[i]  = ct;
    in_valid[i] = 1'b1;
    while (!in_ready[i] && n < 200) begin
      tick();
      n++;
    end
    acc = cyc;
    if (!in_ready[i]) begin
      check("accept_timeout", in_ready[i], 1);
    end else begin
      sbq.push_back('{i, pt, cyc});
      npush++;
    end
    tick();
    in_valid[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 200) begin
      tick();
      n++;
    end
    if (busy[i]) check("idle_timeout", busy[i], 0);
  endtask

  task automatic wait_out(input int i);
    int n = 0;
    while (!out_valid[i] && n < 200) begin
      tick();
      n++;
    end
    if (!out_valid[i]) check("out_valid_timeout", out_valid[i], 1);
  endtask

  task automatic run_rand(input int i);
    logic [127:0] pt;
    int           a;
    pt = r128();
    out_ready[i] = 1'($urandom_range(0, 1));
    send(i, enc(i, pt), pt, a);
    if (!out_ready[i]) begin
      wait_out(i);
      repeat ($urandom_range(0, 4)) tick();
      out_ready[i] = 1'b1;
    end
    wait_idle(i);
    repeat ($urandom_range(0, 2)) tick();
  endtask

  localparam logic [127:0] KAT_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT_K16 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KAT_K32 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KAT_CT10 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT_CT14 = 128'h8ea2b7ca516745bfeafc49904b496089;

  initial begin
    int a1;
    int a2;
    logic [127:0] p1;
    logic [127:0] p2;
    rst = 1'b1;
    in_valid = 2'b00;
    out_ready = 2'b11;
    in_data[0] = '0;
    in_data[1] = '0;
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 16; r++) rk_mem[i][r] = '0;
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("reset_in_ready", in_ready[i], 1);
      check("reset_out_valid", out_valid[i], 0);
      check("reset_out_data", out_data[i], 0);
      check("reset_busy", busy[i], 0);
      check("reset_dp_last", dp_last[i], 0);
      check("reset_rk_addr", rk_addr[i], nr_of(i));
    end

    // Known-answer blocks
    expand(0, {KAT_K16, 128'h0}, 4);
    expand(1, KAT_K32, 8);
    send(0, KAT_CT10, KAT_PT, a1);
    wait_idle(0);
    send(1, KAT_CT14, KAT_PT, a1);
    wait_idle(1);

    // Back-pressure with ignored in_valid pulses
    out_ready[0] = 1'b0;
    send(0, KAT_CT10, KAT_PT, a1);
    wait_out(0);
    for (int k = 0; k < 5; k++) begin
      tick();
      in_valid[0] = 1'(k % 2);
      in_data[0] = r128();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    check("bp_release_in_ready", in_ready[0], 1);
    check("bp_release_busy", busy[0], 0);
    check("bp_release_out_valid", out_valid[0], 0);

    // Back-to-back with in_valid and out_ready held high
    expand(0, {r128(), 128'h0}, 4);
    p1 = r128();
    p2 = r128();
    send(0, enc(0, p1), p1, a1);
    send(0, enc(0, p2), p2, a2);
    check("b2b_accept_gap", a2 - a1, 13);
    wait_idle(0);

    // Reset in the middle of ROUND (cnt=5, so rk_addr=4)
    send(0, enc(0, p1), p1, a1);
    repeat (5) tick();
    check("mid_round_rk_addr", rk_addr[0], 4);
    rst = 1'b1;
    npush -= sbq.size();
    sbq.delete();
    tick();
    rst = 1'b0;
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_out_valid", out_valid[0], 0);
    check("mid_rst_rk_addr", rk_addr[0], 10);
    check("mid_rst_in_ready", in_ready[0], 1);
    repeat (20) tick();
    expand(0, {KAT_K16, 128'h0}, 4);
    send(0, KAT_CT10, KAT_PT, a1);
    wait_idle(0);

    // Random keys and plaintexts, random output stalls
    for (int i = 0; i < 2; i++) begin
      expand(i, (i == 0) ? {r128(), 128'h0} : {r128(), r128()}, (i == 0) ? 4 : 8);
      for (int b = 0; b < 4; b++) run_rand(i);
    end

    repeat (5) tick();
    check("scoreboard_empty", sbq.size(), 0);
    check("output_count", nout, npush);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
